// File: rtl/pmem_responder.sv
// pmem_responder: slave end of the cache's pmem line port. It answers 128-bit
// line reads and writes after a fixed LATENCY and pulses pmem_resp for one cycle.
// Line data lives in an inferred block-RAM array indexed by
// pmem_address[LINES_LOG2+3:4].
// Optional build macro PMEM_RESP_JITTER_EN adds 0..7 cycles of LFSR-driven
// latency jitter. The default build, with the macro undefined, has fixed latency.
module pmem_responder #(
    parameter int LATENCY    = 10,
    parameter int LINES_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int         NLINES = 1 << LINES_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_count;
    logic [11:0]           r_line;      // latched line address (byte address >> 4)
    logic                  r_is_write;
    logic [127:0]          r_wdata;
    logic                  r_resp;
    logic                  r_proto_err;
    logic [127:0]          r_rdata;
    logic [127:0]          r_mem [NLINES];

    logic                  w_req;
    logic                  w_op_write;
    logic [LINES_LOG2-1:0] w_in_idx;
    logic [LINES_LOG2-1:0] w_lat_idx;
    logic [LINES_LOG2-1:0] w_rd_idx;
    logic                  w_rd_is_write;
    logic [7:0]            w_load_count;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_load_rdata;
    logic                  w_mem_we;
    logic                  w_unused;

    // A request with both strobes high is treated as a write.
    assign w_req      = pmem_read | pmem_write;
    assign w_op_write = pmem_write;
    assign w_in_idx   = pmem_address[LINES_LOG2+3:4];
    assign w_lat_idx  = r_line[LINES_LOG2-1:0];
    assign w_accept   = (r_state == IDLE) && w_req;

    // The transition into RESP, as taken by the FSM below.
    // An IDLE request enters RESP directly when the loaded count is zero.
    assign w_enter_resp = (w_accept && (w_load_count == 8'd0)) ||
                          ((r_state == BUSY) && w_req && (r_count <= 8'd1));

    // A direct IDLE->RESP read has not been latched yet, so it uses the live
    // address and op.
    assign w_rd_idx      = (r_state == IDLE) ? w_in_idx   : w_lat_idx;
    assign w_rd_is_write = (r_state == IDLE) ? w_op_write : r_is_write;
    assign w_load_rdata  = w_enter_resp && !w_rd_is_write && !rst;

    // The array is committed on the edge leaving RESP unless reset is asserted
    // on that edge.
    assign w_mem_we = (r_state == RESP) && r_is_write && !rst;

    // Byte-offset bits of the address carry no meaning for a line port.
    assign w_unused = &{1'b0, pmem_address[3:0]};

`ifdef PMEM_RESP_JITTER_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // The jitter uses the LFSR value from before this request advances it.
    assign w_load_count = LAT_M1 + {5'd0, r_lfsr[2:0]};

    // Fibonacci LFSR (taps 8,6,5,4) that steps once per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end
`else
    assign w_load_count = LAT_M1;
`endif

    // Request FSM: accept, count down the latency and pulse the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= 8'd0;
            r_line      <= 12'd0;
            r_is_write  <= 1'b0;
            r_wdata     <= 128'd0;
            r_resp      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_line     <= pmem_address[15:4];
                        r_is_write <= w_op_write;
                        r_wdata    <= pmem_wdata;
                        r_count    <= w_load_count;
                        if (pmem_read && pmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_load_count == 8'd0) begin
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!w_req) begin
                        // The requester withdrew: no response and no array write.
                        r_state <= IDLE;
                        r_count <= 8'd0;
                    end else begin
                        if ((pmem_address[15:4] != r_line) || (w_op_write != r_is_write)) begin
                            r_proto_err <= 1'b1;
                        end
                        if (r_count <= 8'd1) begin
                            r_count <= 8'd0;
                            r_state <= RESP;
                            r_resp  <= 1'b1;
                        end else begin
                            r_count <= r_count - 8'd1;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Line storage write port. Its contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_lat_idx] <= r_wdata;
        end
    end

    // Registered read port. It loads on the edge entering RESP for reads and
    // otherwise holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 128'd0;
        end else if (w_load_rdata) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    assign pmem_rdata = r_rdata;
    assign pmem_resp  = r_resp;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder.
// The bench drives requests, measures response latency in cycles, and checks
// read data, rdata hold and proto_err against a line-array reference model.
module tb_pmem_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .LINES_LOG2(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: line array, last read data, sticky error flag.
    logic [127:0] model_mem [256];
    logic [127:0] model_rdata;
    logic         model_perr;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           drop_at;    // -1: held until resp
        int           exp_lat;    // -1: no response expected
        logic [127:0] exp_rdata;  // checked for completed reads
    } vec_t;

    vec_t tbl[12];

    function automatic int idx_of(input logic [15:0] a);
        return int'(a[11:4]);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic check_lat(input string name, input int lat);
        logic ok;
`ifdef PMEM_RESP_JITTER_EN
        ok = (lat >= LAT) && (lat <= LAT + 7);
`else
        ok = (lat == LAT);
`endif
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: latency %0d, want %0d (+0..7 with jitter)", name, lat, LAT);
    endtask

    // pmem_resp must never be high on two consecutive cycles.
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        if (pmem_resp) begin
            n_checks++;
            if (!prev_resp) n_pass++;
            else $display("FAIL resp_width: resp high on consecutive cycles, want 1-cycle pulse");
        end
        prev_resp = pmem_resp;
    end

    task automatic drop_inputs();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic idle1();
        @(posedge clk); #1;
        drop_inputs();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        drop_inputs();
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        model_rdata = '0;
        model_perr  = 1'b0;
    endtask

    // Cycle 0 is the first cycle with the request high. Returns the cycle in
    // which pmem_resp was seen, or -1 if no response came within the bound.
    // Each cycle, inputs are driven 1 unit after posedge and outputs are
    // sampled at negedge.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int drop_at, input int chg_at,
                           input logic [15:0] chg_addr, input int rst_at,
                           output int lat, output logic [127:0] rd_val);
        lat    = -1;
        rd_val = '0;
        for (int k = 0; k <= LAT + 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                pmem_read    = rd;
                pmem_write   = wr;
                pmem_address = addr;
                pmem_wdata   = wd;
            end
            if (k == drop_at) drop_inputs();
            if (k == chg_at) pmem_address = chg_addr;
            if (k == rst_at) begin
                rst = 1'b1;
                drop_inputs();
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
            if (pmem_resp) begin
                lat    = k;
                rd_val = pmem_rdata;
                break;
            end
        end
        $display("txn rd=%0b wr=%0b addr=%h lat=%0d rdata=%h perr=%0b",
                 rd, wr, addr, lat, rd_val, proto_err);
    endtask

    int           lat;
    logic [127:0] rv;
    logic [127:0] wd;
    logic [15:0]  a;
    int           drop;
    logic         wr;
    int           lat_a[16];

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_rdata = '0;
        model_perr  = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 16'h1230, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_0000_BEEF, -1, LAT, '0};
        tbl[1]  = '{1'b1, 1'b0, 16'h1234, '0, -1, LAT, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_0000_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 16'h0040, {4{32'hA1A1_0001}}, -1, LAT, '0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0080, '0, -1, LAT, 128'h0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0080, {4{32'hB2B2_0002}}, -1, LAT, '0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0080, '0, -1, LAT, {4{32'hB2B2_0002}}};
        tbl[6]  = '{1'b0, 1'b1, 16'h0100, {4{32'hC3C3_0003}}, -1, LAT, '0};
        tbl[7]  = '{1'b0, 1'b1, 16'h0100, {4{32'hD4D4_0004}}, 5, -1, '0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0100, '0, -1, LAT, {4{32'hC3C3_0003}}};
        tbl[9]  = '{1'b0, 1'b1, 16'h5010, {4{32'hE5E5_0005}}, -1, LAT, '0};
        tbl[10] = '{1'b1, 1'b0, 16'h0013, '0, -1, LAT, {4{32'hE5E5_0005}}};
        tbl[11] = '{1'b0, 1'b1, 16'h0400, {4{32'hF6F6_0006}}, -1, LAT, '0};

        rst = 1'b1;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;

        // Reset state and quiet idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_resp", pmem_resp, 1'b0);
            check("idle_rdata", pmem_rdata, '0);
            check("idle_perr", proto_err, 1'b0);
        end

        // Table vectors. Consecutive entries are issued back-to-back.
        for (int i = 0; i < 12; i++) begin
            run_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].drop_at,
                    -1, 16'h0, -1, lat, rv);
            if (tbl[i].exp_lat < 0) begin
                check_int($sformatf("vec%0d_noresp", i), lat, -1);
            end else begin
                check_lat($sformatf("vec%0d_lat", i), lat);
                if (tbl[i].wr) begin
                    check($sformatf("vec%0d_rdata_hold", i), rv, model_rdata);
                    model_mem[idx_of(tbl[i].addr)] = tbl[i].wdata;
                end else begin
                    check($sformatf("vec%0d_rdata", i), rv, tbl[i].exp_rdata);
                    model_rdata = tbl[i].exp_rdata;
                end
            end
            check($sformatf("vec%0d_perr", i), proto_err, 1'b0);
        end

        // Reset during BUSY: no response and the write is discarded.
        run_req(1'b0, 1'b1, 16'h0300, {4{32'h7777_0300}}, -1, -1, 16'h0, 4, lat, rv);
        model_rdata = '0;
        check_int("rst_busy_noresp", lat, -1);
        check("rst_busy_rdata", pmem_rdata, '0);
        idle1();
        run_req(1'b1, 1'b0, 16'h0300, '0, -1, -1, 16'h0, -1, lat, rv);
        check_lat("rst_busy_rd_lat", lat);
        check("rst_busy_rd_data", rv, model_mem[idx_of(16'h0300)]);
        model_rdata = rv;

        // Reset in the RESP cycle: the pulse completes and the array write is suppressed.
        run_req(1'b0, 1'b1, 16'h0310, {4{32'h8888_0310}}, -1, -1, 16'h0, -1, lat, rv);
        check_lat("rst_resp_lat", lat);
        rst = 1'b1;
        drop_inputs();
        @(posedge clk); #1 rst = 1'b0;
        model_rdata = '0;
        run_req(1'b1, 1'b0, 16'h0310, '0, -1, -1, 16'h0, -1, lat, rv);
        check_lat("rst_resp_rd_lat", lat);
        check("rst_resp_rd_data", rv, model_mem[idx_of(16'h0310)]);
        model_rdata = rv;

        // An address change mid-BUSY flags an error and the latched line is still served.
        run_req(1'b1, 1'b0, 16'h0400, '0, -1, 3, 16'h0410, -1, lat, rv);
        check_lat("addr_chg_lat", lat);
        check("addr_chg_data", rv, model_mem[idx_of(16'h0400)]);
        check("addr_chg_perr", proto_err, 1'b1);
        model_rdata = rv;
        run_req(1'b1, 1'b0, 16'h0040, '0, -1, -1, 16'h0, -1, lat, rv);
        check("perr_sticky_data", rv, model_mem[idx_of(16'h0040)]);
        check("perr_sticky", proto_err, 1'b1);
        do_reset(2);
        @(negedge clk);
        check("perr_cleared", proto_err, 1'b0);

        // Read and write together are treated as a write and flag an error.
        run_req(1'b1, 1'b1, 16'h0200, {4{32'h9999_0200}}, -1, -1, 16'h0, -1, lat, rv);
        check_lat("rw_both_lat", lat);
        check("rw_both_perr", proto_err, 1'b1);
        check("rw_both_rdata_hold", rv, model_rdata);
        model_mem[idx_of(16'h0200)] = {4{32'h9999_0200}};
        model_perr = 1'b1;
        idle1();
        run_req(1'b1, 1'b0, 16'h0200, '0, -1, -1, 16'h0, -1, lat, rv);
        check("rw_both_readback", rv, {4{32'h9999_0200}});
        check("rw_both_perr_stays", proto_err, 1'b1);
        model_rdata = rv;

        // Randomised traffic over 16 lines with aliased upper address bits.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            a[11:8] = 4'h0;
            wd = {$urandom, $urandom, $urandom, $urandom};
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_req(!wr, wr, a, wd, drop, -1, 16'h0, -1, lat, rv);
            if (drop >= 0) begin
                check_int($sformatf("rnd%0d_noresp", t), lat, -1);
            end else begin
                check_lat($sformatf("rnd%0d_lat", t), lat);
                if (wr) begin
                    check($sformatf("rnd%0d_rdata_hold", t), rv, model_rdata);
                    model_mem[idx_of(a)] = wd;
                end else begin
                    check($sformatf("rnd%0d_rdata", t), rv, model_mem[idx_of(a)]);
                    model_rdata = model_mem[idx_of(a)];
                end
            end
            check($sformatf("rnd%0d_perr", t), proto_err, model_perr);
            repeat ($urandom_range(0, 2)) idle1();
        end

`ifdef PMEM_RESP_JITTER_EN
        // The jittered latencies must lie in range and repeat identically after reset.
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            run_req(1'b1, 1'b0, 16'(i << 4), '0, -1, -1, 16'h0, -1, lat, rv);
            lat_a[i] = lat;
            check_lat($sformatf("jit_a%0d_lat", i), lat);
            check($sformatf("jit_a%0d_data", i), rv, model_mem[i]);
        end
        do_reset(2);
        for (int i = 0; i < 16; i++) begin
            run_req(1'b1, 1'b0, 16'(i << 4), '0, -1, -1, 16'h0, -1, lat, rv);
            check_int($sformatf("jit_b%0d_repeat", i), lat, lat_a[i]);
        end
`endif

        idle1();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
